// File: rtl/moore_seq_detector_pkg.sv
// Shared definitions for the overlapping serial pattern detector.
// next_state() derives each transition from the pattern itself, so a new
// pattern only needs a different parameter.
package moore_seq_detector_pkg;

  localparam int DEFAULT_PAT_LEN = 5;
  localparam logic [DEFAULT_PAT_LEN-1:0] DEFAULT_PATTERN = 5'b10110;
  localparam int STATE_W = $clog2(DEFAULT_PAT_LEN + 1);
  localparam int MAX_PAT_LEN = 32;

  // State k means "the first k pattern bits have been seen". The successor
  // is the longest pattern prefix that is a suffix of (those k bits, then
  // bit_i). Because k = pat_len is allowed, overlapping matches continue.
  // Codes above pat_len are not real states and fall back to 0.
  function automatic int next_state(
    input int                     state,
    input logic                   bit_i,
    input int                     pat_len = DEFAULT_PAT_LEN,
    input logic [MAX_PAT_LEN-1:0] pattern = MAX_PAT_LEN'(DEFAULT_PATTERN)
  );
    int   best;
    int   si;
    logic ok;
    logic sb;
    if (state < 0 || state > pat_len) return 0;
    best = 0;
    for (int j = 1; j <= pat_len; j++) begin
      if (j <= state + 1) begin
        ok = 1'b1;
        for (int i = 0; i < j; i++) begin
          si = state + 1 - j + i;
          sb = (si == state) ? bit_i : pattern[pat_len-1-si];
          if (sb != pattern[pat_len-1-i]) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/moore_seq_detector.sv
// Moore detector for a fixed serial bit pattern, with overlapping matches.
// The pattern MSB is the first bit received. pattern_o is a decode of the
// state register, so d_i and valid_i have no combinational path to it.
module moore_seq_detector
  import moore_seq_detector_pkg::*;
#(
  parameter int                 PAT_LEN = DEFAULT_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEFAULT_PATTERN)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  input  logic d_i,
  output logic pattern_o
);

  localparam int SW = $clog2(PAT_LEN + 1);
  localparam int NUM_ENC = 2 ** SW;
  localparam logic [SW-1:0] S0 = '0;
  localparam logic [SW-1:0] S_LEN = SW'(PAT_LEN);

  logic [SW-1:0] r_state;
  logic [SW-1:0] w_nextState;
  logic [SW-1:0] w_nsTable [NUM_ENC][2];

  // The transition table is built at elaboration time. It covers every
  // encoding, so indexing with r_state can never leave the array.
  for (genvar s = 0; s < NUM_ENC; s++) begin : g_state
    for (genvar b = 0; b < 2; b++) begin : g_bit
      localparam int NS = next_state(s, 1'(b), PAT_LEN, MAX_PAT_LEN'(PATTERN));
      assign w_nsTable[s][b] = SW'(NS);
    end
  end

  // State register. Reset is asynchronous and forces the no-match state
  // at once, so no partial match survives a reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S0;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state selection and match decode. An illegal code returns to S0
  // whether or not valid_i is high. A valid bit advances the FSM through
  // the table. Otherwise the state holds.
  always_comb begin
    w_nextState = r_state;
    if (int'(r_state) > PAT_LEN) begin
      w_nextState = S0;
    end else if (valid_i) begin
      w_nextState = w_nsTable[r_state][d_i];
    end
    pattern_o = (r_state == S_LEN);
  end

endmodule

// File: tb/tb_moore_seq_detector.sv
// Self-checking bench for moore_seq_detector. The reference model keeps the
// list of valid bits received since the last reset. The expected output is
// high exactly when the newest bits of that list spell the pattern.
module tb_moore_seq_detector;

  localparam int L = 5;
  localparam logic [L-1:0] PAT = 5'b10110;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic valid_i = 1'b0;
  logic d_i = 1'b0;
  logic pattern_o;

  int checkCount = 0;
  int failCount = 0;
  bit histBits[$];

  always #5 clk_i = ~clk_i;

  moore_seq_detector dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .d_i       (d_i),
    .pattern_o (pattern_o)
  );

  // Expected output: do the last L valid bits since reset equal the pattern?
  function automatic bit modelMatch();
    if (histBits.size() < L) return 1'b0;
    for (int i = 0; i < L; i++) begin
      if (histBits[histBits.size()-L+i] != PAT[L-1-i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Count one comparison and report it if the values differ.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of input on the falling edge, then record the bit in
  // the model if the rising edge accepts it. Returns 1 ns after that edge.
  task automatic applyStimulus(input logic v, input logic d);
    @(negedge clk_i);
    valid_i = v;
    d_i = d;
    @(posedge clk_i);
    if (v && rst_i) histBits.push_back(d);
    #1;
  endtask

  // Send n valid bits, MSB first, and check every cycle against the model.
  task automatic sendBits(input logic [15:0] bits, input int n, input string tag,
                          output int pulses);
    pulses = 0;
    for (int i = n - 1; i >= 0; i--) begin
      applyStimulus(1'b1, bits[i]);
      checkOutput(tag, int'(pattern_o), int'(modelMatch()));
      if (pattern_o) pulses++;
    end
  endtask

  // Reset for two cycles while d_i toggles. Output and state must read zero.
  task automatic doReset();
    @(negedge clk_i);
    rst_i = 1'b0;
    histBits.delete();
    #1;
    checkOutput("rst_out", int'(pattern_o), 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'(i));
      checkOutput("rst_hold_out", int'(pattern_o), 0);
      checkOutput("rst_hold_state", int'(dut.r_state), 0);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    int pulses;
    int riseCount;
    int goldenCount;
    logic prevOut;
    bit streamBits[$];

    // 1. Reset from time zero, with d_i toggling.
    valid_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'(i));
      checkOutput("init_rst_out", int'(pattern_o), 0);
      checkOutput("init_rst_state", int'(dut.r_state), 0);
    end
    @(negedge clk_i);
    rst_i = 1'b1;

    // 2. A single match gives a one-cycle pulse.
    sendBits(16'b10110, 5, "single", pulses);
    checkOutput("single_pulses", pulses, 1);
    checkOutput("single_last_high", int'(pattern_o), 1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("single_after", int'(pattern_o), 0);

    // 3. Overlapping matches: two pulses in 8 bits.
    doReset();
    sendBits(16'b10110110, 8, "overlap", pulses);
    checkOutput("overlap_pulses", pulses, 2);

    // 4. Valid gaps: no progress while valid_i is low, and a held match.
    doReset();
    sendBits(16'b101, 3, "gap_pre", pulses);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)));
      checkOutput("gap_idle", int'(pattern_o), int'(modelMatch()));
    end
    sendBits(16'b10, 2, "gap_post", pulses);
    checkOutput("gap_pulses", pulses, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)));
      checkOutput("hold_match", int'(pattern_o), 1);
    end
    applyStimulus(1'b1, 1'b1);
    checkOutput("hold_release", int'(pattern_o), 0);

    // 5. Asynchronous reset partway through a match.
    doReset();
    sendBits(16'b1011, 4, "mid_pre", pulses);
    #3;
    rst_i = 1'b0;
    histBits.delete();
    #1;
    checkOutput("mid_rst_state", int'(dut.r_state), 0);
    checkOutput("mid_rst_out", int'(pattern_o), 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    sendBits(16'b0, 1, "mid_post", pulses);
    checkOutput("mid_pulses", pulses, 0);

    // 6. 600 random valid bits. Count rising edges against a direct search.
    doReset();
    streamBits.delete();
    riseCount = 0;
    prevOut = pattern_o;
    for (int i = 0; i < 600; i++) begin
      logic b;
      b = 1'($urandom_range(0, 1));
      streamBits.push_back(b);
      applyStimulus(1'b1, b);
      checkOutput("rand_cycle", int'(pattern_o), int'(modelMatch()));
      if (pattern_o && !prevOut) riseCount++;
      prevOut = pattern_o;
    end
    goldenCount = 0;
    for (int i = L - 1; i < streamBits.size(); i++) begin
      logic hit;
      hit = 1'b1;
      for (int k = 0; k < L; k++) begin
        if (streamBits[i-L+1+k] != PAT[L-1-k]) hit = 1'b0;
      end
      if (hit) goldenCount++;
    end
    checkOutput("rand_rise_count", riseCount, goldenCount);

    // Random valid_i and d_i together, checked cycle by cycle.
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checkOutput("rand_valid", int'(pattern_o), int'(modelMatch()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
